// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter for the shared 32-bit datapath bus, with lock-extended bursts.
// Optional BUS_PC_PRIORITY_EN: source 20 (PC) wins every arbitration and never extends.
module bus_source_arbiter #(
    parameter int unsigned NUM_SRC  = 24,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IDLE_SEL = 31
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_SRC-1:0] req,
    input  logic               lock,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   select_signal,
    output logic               bus_valid,
    output logic [3:0]         hold_cnt
);

    localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CandW = IdxW + 1;
`ifdef BUS_PC_PRIORITY_EN
    localparam bit          HasPc = (NUM_SRC > 20);
    localparam int unsigned PcBit = HasPc ? 20 : 0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StLocked
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic [3:0]           hold_q, hold_d;
    logic [IdxW-1:0]      last_q, last_d;

    logic                 found;
    logic [IdxW-1:0]      winner;
    logic [CandW-1:0]     cand;
    logic                 extend;

    // Rotating search starting just after the last grantee; the extra candidate bit
    // holds last_q + i before the wrap back into range.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = {1'b0, last_q} + CandW'(i);
            if (cand >= CandW'(NUM_SRC)) begin
                cand = cand - CandW'(NUM_SRC);
            end
            if (!found && req[cand[IdxW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IdxW-1:0];
            end
        end
`ifdef BUS_PC_PRIORITY_EN
        if (HasPc && req[PcBit]) begin
            found  = 1'b1;
            winner = IdxW'(PcBit);
        end
`endif
    end

    // While a grant is live the grantee is always last_q.
    always_comb begin
        extend = (state_q != StIdle) && req[last_q] && lock && (32'(hold_q) < MAX_HOLD);
`ifdef BUS_PC_PRIORITY_EN
        if (HasPc && (last_q == IdxW'(PcBit))) begin
            extend = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        last_d  = last_q;
        if (extend) begin
            state_d = StLocked;
            hold_d  = hold_q + 4'd1;
        end else if (found) begin
            state_d = StGrant;
            grant_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << winner;
            sel_d   = SEL_W'(winner);
            valid_d = 1'b1;
            hold_d  = 4'd1;
            last_d  = winner;
        end else begin
            state_d = StIdle;
            grant_d = '0;
            sel_d   = SEL_W'(IDLE_SEL);
            valid_d = 1'b0;
            hold_d  = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            grant_q <= '0;
            sel_q   <= SEL_W'(IDLE_SEL);
            valid_q <= 1'b0;
            hold_q  <= 4'd0;
            last_q  <= IdxW'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign grant         = grant_q;
    assign select_signal = sel_q;
    assign bus_valid     = valid_q;
    assign hold_cnt      = hold_q;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (clr) $onehot0(grant_q));
    a_valid_match   : assert property (@(posedge clk) disable iff (clr) valid_q == |grant_q);
    a_hold_bound    : assert property (@(posedge clk) disable iff (clr)
                                       32'(hold_q) <= MAX_HOLD);

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Randomized + directed bench for bus_source_arbiter against a behavioural model.
// A second, narrow instance (20 sources, MAX_HOLD=1) covers the boundary builds.
module tb_bus_source_arbiter;

    localparam int N = 24;
    localparam int MAXH = 4;
    localparam int NS = 20;
    localparam int MAXHS = 1;
    localparam int IDLE = 31;
`ifdef BUS_PC_PRIORITY_EN
    localparam bit PcEn = 1'b1;
`else
    localparam bit PcEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        lock = 1'b0;
    logic [23:0] req = '0;

    logic [23:0] grant;
    logic [4:0]  select_signal;
    logic        bus_valid;
    logic [3:0]  hold_cnt;

    logic [19:0] grant_s;
    logic [4:0]  select_s;
    logic        valid_s;
    logic [3:0]  hold_s;

    int checks = 0;
    int failures = 0;

    int m_own, m_cnt, m_last;
    int s_own, s_cnt, s_last;

    always #5 clk = ~clk;

    bus_source_arbiter #(
        .NUM_SRC (N),
        .SEL_W   (5),
        .MAX_HOLD(MAXH),
        .IDLE_SEL(IDLE)
    ) u_dut (
        .clk          (clk),
        .clr          (clr),
        .req          (req),
        .lock         (lock),
        .grant        (grant),
        .select_signal(select_signal),
        .bus_valid    (bus_valid),
        .hold_cnt     (hold_cnt)
    );

    bus_source_arbiter #(
        .NUM_SRC (NS),
        .SEL_W   (5),
        .MAX_HOLD(MAXHS),
        .IDLE_SEL(IDLE)
    ) u_dut_small (
        .clk          (clk),
        .clr          (clr),
        .req          (req[19:0]),
        .lock         (lock),
        .grant        (grant_s),
        .select_signal(select_s),
        .bus_valid    (valid_s),
        .hold_cnt     (hold_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of the arbitration rules: owner -1 means the bus is idle.
    task automatic model(input int n, input int maxh, input logic [23:0] r, input logic lk,
                         input logic c, input int own_i, input int cnt_i, input int last_i,
                         output int own_o, output int cnt_o, output int last_o);
        int win;
        own_o = own_i;
        cnt_o = cnt_i;
        last_o = last_i;
        if (c) begin
            own_o = -1;
            cnt_o = 0;
            last_o = n - 1;
            return;
        end
        if (own_i >= 0 && r[own_i] && lk && cnt_i < maxh && !(PcEn && n > 20 && own_i == 20)) begin
            cnt_o = cnt_i + 1;
            return;
        end
        win = -1;
        if (PcEn && n > 20 && r[20]) win = 20;
        for (int k = 1; k <= n; k++) begin
            if (win < 0 && r[(last_i + k) % n]) win = (last_i + k) % n;
        end
        if (win >= 0) begin
            own_o = win;
            cnt_o = 1;
            last_o = win;
        end else begin
            own_o = -1;
            cnt_o = 0;
        end
    endtask

    function automatic logic [31:0] exp_grant(input int own);
        return (own >= 0) ? (32'd1 << own) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_sel(input int own);
        return (own >= 0) ? 32'(own) : 32'(IDLE);
    endfunction

    task automatic step(input logic [23:0] r, input logic lk, input logic c);
        req = r;
        lock = lk;
        clr = c;
        @(posedge clk);
        model(N, MAXH, r, lk, c, m_own, m_cnt, m_last, m_own, m_cnt, m_last);
        model(NS, MAXHS, r, lk, c, s_own, s_cnt, s_last, s_own, s_cnt, s_last);
        #1;
        check("sel", 32'(select_signal), exp_sel(m_own));
        check("grant", 32'(grant), exp_grant(m_own));
        check("valid", 32'(bus_valid), 32'(m_own >= 0));
        check("hold", 32'(hold_cnt), 32'(m_cnt));
        check("s_sel", 32'(select_s), exp_sel(s_own));
        check("s_grant", 32'(grant_s), exp_grant(s_own));
        check("s_hold", 32'(hold_s), 32'(s_cnt));
    endtask

    function automatic logic [23:0] bits(input int a, input int b, input int c);
        logic [23:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    int exp_rr[6] = '{3, 16, 21, 3, 16, 21};
    int exp_bs[9] = '{5, 5, 5, 5, 21, 21, 21, 21, 5};
    int exp_bh[9] = '{1, 2, 3, 4, 1, 2, 3, 4, 1};

    initial begin
        logic [23:0] r;
        logic        lk;
        logic        c;

        // Reset then idle
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        check("rst_sel", 32'(select_signal), 32'd31);
        check("rst_valid", 32'(bus_valid), 32'd0);
        step('0, 1'b1, 1'b0);
        check("idle_lock_hold", 32'(hold_cnt), 32'd0);

        // Round-robin over 3, 16, 21
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(bits(3, 16, 21), 1'b0, 1'b0);
            check("rr_sel", 32'(select_signal), 32'(exp_rr[i]));
        end

        // Burst cap with lock held
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(bits(5, 21, -1), 1'b1, 1'b0);
            check("burst_sel", 32'(select_signal), 32'(exp_bs[i]));
            check("burst_hold", 32'(hold_cnt), 32'(exp_bh[i]));
        end

        // Early release of a locked R7
        step('0, 1'b0, 1'b1);
        step(bits(7, -1, -1), 1'b1, 1'b0);
        step(bits(7, -1, -1), 1'b1, 1'b0);
        check("lock7_hold", 32'(hold_cnt), 32'd2);
        step(bits(19, -1, -1), 1'b1, 1'b0);
        check("rel_sel", 32'(select_signal), 32'd19);
        check("rel_hold", 32'(hold_cnt), 32'd1);

        // Reset mid-burst
        step(bits(7, -1, -1), 1'b1, 1'b0);
        step(bits(7, -1, -1), 1'b1, 1'b0);
        step(bits(7, -1, -1), 1'b1, 1'b1);
        check("midrst_valid", 32'(bus_valid), 32'd0);
        step(bits(9, 2, -1), 1'b0, 1'b0);
        check("midrst_next", 32'(select_signal), 32'd2);

        // Wrap from 23
        step('0, 1'b0, 1'b1);
        step(bits(23, -1, -1), 1'b0, 1'b0);
        check("wrap_23", 32'(select_signal), 32'd23);
        step(bits(0, 22, -1), 1'b0, 1'b0);
        check("wrap_0", 32'(select_signal), 32'd0);
        step(bits(0, 22, -1), 1'b0, 1'b0);
        check("wrap_22", 32'(select_signal), 32'd22);

`ifdef BUS_PC_PRIORITY_EN
        step('0, 1'b0, 1'b1);
        step(bits(3, -1, -1), 1'b0, 1'b0);
        step(bits(20, 4, -1), 1'b1, 1'b0);
        check("pc_win", 32'(select_signal), 32'd20);
        step(bits(4, -1, -1), 1'b1, 1'b0);
        check("pc_then4", 32'(select_signal), 32'd4);
        step(bits(4, 20, -1), 1'b1, 1'b0);
        step(bits(4, 20, -1), 1'b1, 1'b0);
        step(bits(4, 20, -1), 1'b1, 1'b0);
        check("pc_burst4", 32'(hold_cnt), 32'd4);
        step(bits(4, 20, -1), 1'b1, 1'b0);
        check("pc_after", 32'(select_signal), 32'd20);
`endif

        // Randomized traffic, sticky requests so bursts and releases both occur
        r = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0) r = 24'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0) r = '0;
            lk = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) == 0);
            step(r, lk, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
